// File: rtl/vram_arb_pkg.sv
// Shared types and widths for the VRAM arbiter: grant sources, prefetch states,
// CPU write-FIFO entry layout and byte-lane helpers.
package vram_arb_pkg;

  localparam int unsigned CPU_AW  = 14;
  localparam int unsigned VRAM_AW = 13;
  localparam int unsigned VRAM_DW = 16;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned BE_W    = 2;
  localparam int unsigned WAIT_W  = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REN  = 2'd1,
    GNT_WR   = 2'd2,
    GNT_PF   = 2'd3
  } gnt_e;

  typedef enum logic [1:0] {
    PF_IDLE = 2'd0,
    PF_WAIT = 2'd1,
    PF_READ = 2'd2
  } pf_state_e;

  typedef struct packed {
    logic [CPU_AW-1:0] addr;
    logic [BYTE_W-1:0] data;
  } wr_entry_t;

  // Byte address bit 0 picks the lane: 0 -> [7:0], 1 -> [15:8]
  function automatic logic [BYTE_W-1:0] sel_byte(input logic [VRAM_DW-1:0] word, input logic hi);
    return hi ? word[VRAM_DW-1:BYTE_W] : word[BYTE_W-1:0];
  endfunction

  function automatic logic [BE_W-1:0] byte_be(input logic hi);
    return hi ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO of buffered CPU byte writes; accepts a push while full when
// the head is popped in the same cycle.
module vram_wr_fifo
  import vram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wr_entry_t              push_data,
  input  logic                   pop,
  output wr_entry_t              head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wr_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full     = (cnt_q == CNT_W'(DEPTH));
    empty    = (cnt_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: renderer > buffered CPU write > CPU read-ahead.
// Define VRAM_ARB_FAIR_EN to force a CPU slot after CPU_MAX_WAIT denied cycles.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned WR_FIFO_DEPTH = 4,
  parameter int unsigned CPU_MAX_WAIT  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_wr_valid,
  input  logic [CPU_AW-1:0]  cpu_wr_addr,
  input  logic [BYTE_W-1:0]  cpu_wr_data,
  output logic               cpu_wr_ready,
  input  logic               cpu_pf_start,
  input  logic [CPU_AW-1:0]  cpu_pf_addr,
  output logic [BYTE_W-1:0]  cpu_rd_data,
  output logic               cpu_rd_valid,
  input  logic               ren_req,
  input  logic [VRAM_AW-1:0] ren_addr,
  output logic               ren_ack,
  output logic               ren_rdvalid,
  output logic [VRAM_DW-1:0] ren_rddata,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [VRAM_DW-1:0] vram_wrdata,
  output logic [BE_W-1:0]    vram_wrbe,
  input  logic [VRAM_DW-1:0] vram_rddata
);

  localparam int unsigned CNT_W = $clog2(WR_FIFO_DEPTH) + 1;

  if (WR_FIFO_DEPTH < 2 || (WR_FIFO_DEPTH & (WR_FIFO_DEPTH - 1)) != 32'd0) begin : g_bad_depth
    $error("WR_FIFO_DEPTH must be a power of two >= 2");
  end
  if (CPU_MAX_WAIT < 1 || CPU_MAX_WAIT > 15) begin : g_bad_wait
    $error("CPU_MAX_WAIT must fit the 4-bit starvation counter");
  end

  wr_entry_t          push_entry, head;
  logic               fifo_empty, push_c, pop_c, wr_elig, pf_elig, force_c;
  logic [CNT_W-1:0]   fifo_count, fifo_cnt_nxt;
  gnt_e               gnt;
  pf_state_e          pf_state_q, pf_state_d;
  logic [CPU_AW-1:0]  pf_addr_q, pf_addr_d;
  logic [BYTE_W-1:0]  cpu_rd_data_q, cpu_rd_data_d;
  logic               cpu_rd_valid_q, cpu_rd_valid_d;
  logic               cpu_wr_ready_q, cpu_wr_ready_d;
  logic               ren_rdvalid_q, ren_rdvalid_d;
  logic [VRAM_DW-1:0] ren_rddata_q, ren_rddata_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic [VRAM_DW-1:0] vram_wrdata_q, vram_wrdata_d;

  assign push_entry = '{addr: cpu_wr_addr, data: cpu_wr_data};

  vram_wr_fifo #(.DEPTH(WR_FIFO_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_entry),
    .pop       (pop_c),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Read-ahead only issues once every earlier write has drained
  always_comb begin
    push_c  = cpu_wr_valid && cpu_wr_ready_q;
    wr_elig = !fifo_empty;
    pf_elig = (pf_state_q == PF_WAIT) && fifo_empty && !push_c && !cpu_pf_start;
  end

`ifdef VRAM_ARB_FAIR_EN
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign force_c = (wait_cnt_q >= WAIT_W'(CPU_MAX_WAIT)) && (wr_elig || pf_elig);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (gnt == GNT_WR || gnt == GNT_PF) begin
      wait_cnt_d = '0;
    end else if ((wr_elig || pf_state_q == PF_WAIT) && wait_cnt_q != '1) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`else
  assign force_c = 1'b0;
`endif

  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (ren_req && !force_c) gnt = GNT_REN;
      else if (wr_elig)        gnt = GNT_WR;
      else if (pf_elig)        gnt = GNT_PF;
    end
  end

  // VRAM command; address and write data hold their last value when idle
  always_comb begin
    pop_c         = (gnt == GNT_WR);
    vram_addr_d   = vram_addr_q;
    vram_wrdata_d = vram_wrdata_q;
    vram_wrbe     = '0;
    case (gnt)
      GNT_REN: vram_addr_d = ren_addr;
      GNT_WR: begin
        vram_addr_d   = head.addr[CPU_AW-1:1];
        vram_wrdata_d = {head.data, head.data};
        vram_wrbe     = byte_be(head.addr[0]);
      end
      GNT_PF:  vram_addr_d = pf_addr_q[CPU_AW-1:1];
      default: ;
    endcase
    fifo_cnt_nxt   = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
    cpu_wr_ready_d = (fifo_cnt_nxt != CNT_W'(WR_FIFO_DEPTH));
    ren_rdvalid_d  = (gnt == GNT_REN);
    ren_rddata_d   = ren_rdvalid_q ? vram_rddata : ren_rddata_q;
  end

  // Read-ahead FSM; a new start always wins and drops any in-flight byte
  always_comb begin
    pf_state_d     = pf_state_q;
    pf_addr_d      = pf_addr_q;
    cpu_rd_data_d  = cpu_rd_data_q;
    cpu_rd_valid_d = cpu_rd_valid_q;
    if (cpu_pf_start) begin
      pf_state_d     = PF_WAIT;
      pf_addr_d      = cpu_pf_addr;
      cpu_rd_valid_d = 1'b0;
    end else begin
      case (pf_state_q)
        PF_WAIT: if (gnt == GNT_PF) pf_state_d = PF_READ;
        PF_READ: begin
          pf_state_d     = PF_IDLE;
          cpu_rd_data_d  = sel_byte(vram_rddata, pf_addr_q[0]);
          cpu_rd_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_state_q     <= PF_IDLE;
      pf_addr_q      <= '0;
      cpu_rd_data_q  <= '0;
      cpu_rd_valid_q <= 1'b0;
      cpu_wr_ready_q <= 1'b1;
      ren_rdvalid_q  <= 1'b0;
      ren_rddata_q   <= '0;
      vram_addr_q    <= '0;
      vram_wrdata_q  <= '0;
    end else begin
      pf_state_q     <= pf_state_d;
      pf_addr_q      <= pf_addr_d;
      cpu_rd_data_q  <= cpu_rd_data_d;
      cpu_rd_valid_q <= cpu_rd_valid_d;
      cpu_wr_ready_q <= cpu_wr_ready_d;
      ren_rdvalid_q  <= ren_rdvalid_d;
      ren_rddata_q   <= ren_rddata_d;
      vram_addr_q    <= vram_addr_d;
      vram_wrdata_q  <= vram_wrdata_d;
    end
  end

  assign ren_ack      = (gnt == GNT_REN);
  assign ren_rdvalid  = ren_rdvalid_q;
  assign ren_rddata   = ren_rddata_d;
  assign cpu_rd_data  = cpu_rd_data_q;
  assign cpu_rd_valid = cpu_rd_valid_q;
  assign cpu_wr_ready = cpu_wr_ready_q;
  assign vram_addr    = vram_addr_d;
  assign vram_wrdata  = vram_wrdata_d;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency VRAM.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_wr_valid;
  logic [13:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_ready;
  logic        cpu_pf_start;
  logic [13:0] cpu_pf_addr;
  logic [7:0]  cpu_rd_data;
  logic        cpu_rd_valid;
  logic        ren_req;
  logic [12:0] ren_addr;
  logic        ren_ack;
  logic        ren_rdvalid;
  logic [15:0] ren_rddata;
  logic [12:0] vram_addr;
  logic [15:0] vram_wrdata;
  logic [1:0]  vram_wrbe;
  logic [15:0] vram_rddata;

  logic [15:0] mem [8192];
  logic        bd_we = 1'b0;
  logic [12:0] bd_addr = '0;
  logic [15:0] bd_data = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.WR_FIFO_DEPTH(4), .CPU_MAX_WAIT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_wr_valid (cpu_wr_valid),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_pf_start (cpu_pf_start),
    .cpu_pf_addr  (cpu_pf_addr),
    .cpu_rd_data  (cpu_rd_data),
    .cpu_rd_valid (cpu_rd_valid),
    .ren_req      (ren_req),
    .ren_addr     (ren_addr),
    .ren_ack      (ren_ack),
    .ren_rdvalid  (ren_rdvalid),
    .ren_rddata   (ren_rddata),
    .vram_addr    (vram_addr),
    .vram_wrdata  (vram_wrdata),
    .vram_wrbe    (vram_wrbe),
    .vram_rddata  (vram_rddata)
  );

  // VRAM model with a backdoor preload port
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else begin
      if (vram_wrbe[0]) mem[vram_addr][7:0]  <= vram_wrdata[7:0];
      if (vram_wrbe[1]) mem[vram_addr][15:8] <= vram_wrdata[15:8];
    end
    vram_rddata <= mem[vram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [12:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic check_wr(input string tag, input logic [12:0] a, input logic [1:0] be,
                          input logic [15:0] d);
    check({tag, "_addr"}, 32'(vram_addr), 32'(a));
    check({tag, "_be"}, 32'(vram_wrbe), 32'(be));
    check({tag, "_data"}, 32'(vram_wrdata), 32'(d));
  endtask

  initial begin
    reset = 1'b1;
    cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
    cpu_pf_start = 1'b0; cpu_pf_addr = '0;
    ren_req = 1'b0; ren_addr = '0;
    tick(); tick();

    check("rst_wr_ready", 32'(cpu_wr_ready), 32'd1);
    check("rst_rd_valid", 32'(cpu_rd_valid), 32'd0);
    check("rst_rd_data", 32'(cpu_rd_data), 32'd0);
    check("rst_ren_ack", 32'(ren_ack), 32'd0);
    check("rst_ren_rdvalid", 32'(ren_rdvalid), 32'd0);
    check("rst_ren_rddata", 32'(ren_rddata), 32'd0);
    check("rst_wrbe", 32'(vram_wrbe), 32'd0);
    check("rst_vram_addr", 32'(vram_addr), 32'd0);
    check("rst_wrdata", 32'(vram_wrdata), 32'd0);
    reset = 1'b0;

    preload(13'h0008, 16'h5511);
    preload(13'h0010, 16'h6622);
    preload(13'h1FFF, 16'hBEEF);

    // Single byte write to odd address -> high lane, replicated data
    tick(); cpu_wr_valid = 1'b1; cpu_wr_addr = 14'h0001; cpu_wr_data = 8'hA5;
    tick(); cpu_wr_valid = 1'b0; #1;
    check_wr("wr1", 13'h0000, 2'b10, 16'hA5A5);
    check("wr1_ren_ack", 32'(ren_ack), 32'd0);
    tick();
    check("idle_wrbe", 32'(vram_wrbe), 32'd0);
    check("idle_wrdata_hold", 32'(vram_wrdata), 32'hA5A5);

    // Read-ahead of the high byte just written
    tick(); cpu_pf_start = 1'b1; cpu_pf_addr = 14'h0001;
    tick(); cpu_pf_start = 1'b0; #1;
    check("pf1_issue_addr", 32'(vram_addr), 32'h0000);
    check("pf1_issue_be", 32'(vram_wrbe), 32'd0);
    check("pf1_valid_wait", 32'(cpu_rd_valid), 32'd0);
    tick();
    check("pf1_valid_read", 32'(cpu_rd_valid), 32'd0);
    tick();
    check("pf1_valid", 32'(cpu_rd_valid), 32'd1);
    check("pf1_data", 32'(cpu_rd_data), 32'hA5);

    // Renderer held high: fill the FIFO, then drain in order
    tick(); ren_req = 1'b1; ren_addr = 13'h0123;
    cpu_wr_valid = 1'b1; cpu_wr_addr = 14'h0002; cpu_wr_data = 8'h11; #1;
    check("fill_ren_ack", 32'(ren_ack), 32'd1);
    check("fill_ready0", 32'(cpu_wr_ready), 32'd1);
    tick(); cpu_wr_addr = 14'h0003; cpu_wr_data = 8'h22;
    tick(); cpu_wr_addr = 14'h0004; cpu_wr_data = 8'h33;
    tick(); cpu_wr_addr = 14'h0005; cpu_wr_data = 8'h44;
    tick(); cpu_wr_addr = 14'h0006; cpu_wr_data = 8'h55; #1;
    check("full_ready", 32'(cpu_wr_ready), 32'd0);
    tick();
    check("full_ready_c5", 32'(cpu_wr_ready), 32'd0);
    check("full_wrbe_c5", 32'(vram_wrbe), 32'd0);
    tick();
    check("full_ready_c6", 32'(cpu_wr_ready), 32'd0);
    tick(); ren_req = 1'b0; #1;
    check_wr("drain0", 13'h0001, 2'b01, 16'h1111);
    check("drain0_ready", 32'(cpu_wr_ready), 32'd0);
    tick();
    check("drain1_ready", 32'(cpu_wr_ready), 32'd1);
    check_wr("drain1", 13'h0001, 2'b10, 16'h2222);
    tick(); cpu_wr_valid = 1'b0; #1;
    check_wr("drain2", 13'h0002, 2'b01, 16'h3333);
    tick();
    check_wr("drain3", 13'h0002, 2'b10, 16'h4444);
    tick();
    check_wr("drain4", 13'h0003, 2'b01, 16'h5555);
    tick();
    check("drained_wrbe", 32'(vram_wrbe), 32'd0);

    // Write and read-ahead of the same byte in one cycle: read follows write
    tick(); cpu_wr_valid = 1'b1; cpu_wr_addr = 14'h0100; cpu_wr_data = 8'h3C;
    cpu_pf_start = 1'b1; cpu_pf_addr = 14'h0100;
    tick(); cpu_wr_valid = 1'b0; cpu_pf_start = 1'b0; #1;
    check_wr("raw_wr", 13'h0080, 2'b01, 16'h3C3C);
    check("raw_valid_clr", 32'(cpu_rd_valid), 32'd0);
    tick();
    check("raw_pf_addr", 32'(vram_addr), 32'h0080);
    check("raw_pf_be", 32'(vram_wrbe), 32'd0);
    tick();
    check("raw_valid_read", 32'(cpu_rd_valid), 32'd0);
    tick();
    check("raw_valid", 32'(cpu_rd_valid), 32'd1);
    check("raw_data", 32'(cpu_rd_data), 32'h3C);

    // Restart during PF_READ discards the first byte
    tick(); cpu_pf_start = 1'b1; cpu_pf_addr = 14'h0010;
    tick(); cpu_pf_start = 1'b0; #1;
    check("rs_issue1", 32'(vram_addr), 32'h0008);
    tick(); cpu_pf_start = 1'b1; cpu_pf_addr = 14'h0020; #1;
    check("rs_valid_r1", 32'(cpu_rd_valid), 32'd0);
    tick(); cpu_pf_start = 1'b0; #1;
    check("rs_issue2", 32'(vram_addr), 32'h0010);
    check("rs_valid_w2", 32'(cpu_rd_valid), 32'd0);
    tick();
    check("rs_valid_r2", 32'(cpu_rd_valid), 32'd0);
    tick();
    check("rs_valid", 32'(cpu_rd_valid), 32'd1);
    check("rs_data", 32'(cpu_rd_data), 32'h22);
    tick();
    check("rs_data_hold", 32'(cpu_rd_data), 32'h22);

    // Renderer fetch at top word
    tick(); ren_req = 1'b1; ren_addr = 13'h1FFF; #1;
    check("ren_ack", 32'(ren_ack), 32'd1);
    check("ren_addr", 32'(vram_addr), 32'h1FFF);
    check("ren_be", 32'(vram_wrbe), 32'd0);
    check("ren_rdvalid_c0", 32'(ren_rdvalid), 32'd0);
    tick(); ren_req = 1'b0; #1;
    check("ren_ack_off", 32'(ren_ack), 32'd0);
    check("ren_rdvalid", 32'(ren_rdvalid), 32'd1);
    check("ren_rddata", 32'(ren_rddata), 32'hBEEF);
    tick();
    check("ren_rdvalid_off", 32'(ren_rdvalid), 32'd0);
    check("ren_rddata_hold", 32'(ren_rddata), 32'hBEEF);

    // Reset mid-operation drops buffered writes and the pending read-ahead
    tick(); ren_req = 1'b1; ren_addr = 13'h0010;
    cpu_wr_valid = 1'b1; cpu_wr_addr = 14'h0300; cpu_wr_data = 8'h99;
    tick(); cpu_wr_addr = 14'h0301; cpu_wr_data = 8'h98;
    cpu_pf_start = 1'b1; cpu_pf_addr = 14'h0040;
    tick(); reset = 1'b1; cpu_wr_valid = 1'b0; cpu_pf_start = 1'b0; ren_req = 1'b0; #1;
    check("mrst_wrbe_in_reset", 32'(vram_wrbe), 32'd0);
    tick(); reset = 1'b0; #1;
    check("mrst_ready", 32'(cpu_wr_ready), 32'd1);
    check("mrst_vram_addr", 32'(vram_addr), 32'd0);
    check("mrst_rd_valid", 32'(cpu_rd_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_idle_wrbe", 32'(vram_wrbe), 32'd0);
      check("mrst_idle_rdvalid", 32'(cpu_rd_valid), 32'd0);
    end

    // Renderer stuck high with one pending write
    tick(); ren_req = 1'b1; ren_addr = 13'h0400;
    cpu_wr_valid = 1'b1; cpu_wr_addr = 14'h0200; cpu_wr_data = 8'h77;
    for (int c = 1; c <= 12; c++) begin
      logic exp_ack;
      logic [1:0] exp_be;
      tick(); cpu_wr_valid = 1'b0; #1;
`ifdef VRAM_ARB_FAIR_EN
      exp_ack = (c != 9);
      exp_be  = (c == 9) ? 2'b01 : 2'b00;
`else
      exp_ack = 1'b1;
      exp_be  = 2'b00;
`endif
      check("stv_ren_ack", 32'(ren_ack), 32'(exp_ack));
      check("stv_wrbe", 32'(vram_wrbe), 32'(exp_be));
    end
    tick(); ren_req = 1'b0; #1;
`ifdef VRAM_ARB_FAIR_EN
    check("stv_after_be", 32'(vram_wrbe), 32'd0);
`else
    check_wr("stv_release", 13'h0100, 2'b01, 16'h7777);
`endif
    tick();
    check("stv_final_be", 32'(vram_wrbe), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port, 16-bit-wide synchronous VRAM between two requesters: the scanline renderer (word fetches) and the CPU data port (byte writes, plus a one-byte read-ahead buffer).
- Sits between the register interface / gfx renderer and the VRAM macro, inside the video clock domain.
- Renderer has strict priority.
- CPU writes are buffered in a small FIFO. Reads stay coherent with buffered writes.

Parameters:
- WR_FIFO_DEPTH, 4, CPU write FIFO entries; power of two, >= 2.
- CPU_MAX_WAIT, 8, cycles a CPU request may starve before a forced slot (used only with VRAM_ARB_FAIR_EN).

Ports:
- clk  in  1  video clock
- reset  in  1  synchronous, active-high
- cpu_wr_valid  in  1  CPU byte write request
- cpu_wr_addr  in  14  byte address
- cpu_wr_data  in  8  write byte
- cpu_wr_ready  out  1  FIFO not full
- cpu_pf_start  in  1  pulse: (re)start read-ahead at cpu_pf_addr
- cpu_pf_addr  in  14  read-ahead byte address
- cpu_rd_data  out  8  read-ahead buffer
- cpu_rd_valid  out  1  buffer holds data for the last cpu_pf_start
- ren_req  in  1  renderer fetch request
- ren_addr  in  13  word address
- ren_ack  out  1  request issued this cycle
- ren_rdvalid  out  1  ren_rddata valid
- ren_rddata  out  16  fetched word
- vram_addr  out  13  word address
- vram_wrdata  out  16  write data
- vram_wrbe  out  2  byte write enables
- vram_rddata  in  16  read data, 1-cycle latency

Behaviour:
- Reset: FIFO empty, prefetch FSM in PF_IDLE.
  - Outputs: cpu_wr_ready=1, cpu_rd_valid=0, cpu_rd_data=0, ren_ack=0, ren_rdvalid=0, ren_rddata=0, vram_wrbe=0, vram_addr=0, vram_wrdata=0.
  - Reset mid-operation discards FIFO contents and any in-flight read.
- Byte mapping: addr[13:1] is the word; addr[0]=0 selects bits [7:0], addr[0]=1 selects bits [15:8].
  - Writes replicate the byte to both halves of vram_wrdata; vram_wrbe is one-hot per addr[0].
- Slot grant is one access per cycle, priority: renderer > FIFO head write > prefetch read.
  - ren_ack is combinational with ren_req when granted, which is always in the default build.
  - ren_rdvalid/ren_rddata register vram_rddata one cycle after ren_ack (latency 1).
- FIFO:
  - Push when cpu_wr_valid && cpu_wr_ready.
  - Pop when the head is granted.
  - Push and pop in the same cycle while full is legal; the count is unchanged.
  - cpu_wr_ready = !full, registered.
- Prefetch FSM:
  - PF_IDLE -> PF_WAIT on cpu_pf_start: latch the address, clear cpu_rd_valid.
  - PF_WAIT -> PF_READ when the FIFO is empty, no push is occurring, and the slot is free. Address is issued in this cycle.
  - PF_READ -> PF_IDLE next cycle: the selected byte is loaded into cpu_rd_data and cpu_rd_valid=1.
  - cpu_pf_start in PF_WAIT or PF_READ restarts PF_WAIT with the new address; in-flight data is discarded and cpu_rd_valid stays 0.
  - Simultaneous cpu_wr_valid and cpu_pf_start: the write is pushed first; the prefetch waits for the drain (read-after-write ordering).
- Address 0x3FFF wraps naturally; the arbiter does no arithmetic on addresses.
- No VRAM access when idle: vram_wrbe=0, vram_addr holds its last value.

Optional Feature:
- VRAM_ARB_FAIR_EN defined:
  - A 4-bit counter increments each cycle a CPU write or prefetch is pending and denied.
  - When the count reaches CPU_MAX_WAIT, the next cycle grants the CPU and ren_ack=0 for that cycle; the counter then clears.
  - The renderer must tolerate ren_ack=0.
- Undefined: pure renderer priority; the CPU can starve indefinitely.

Decomposition:
- Package vram_arb_pkg: grant-source constants (GNT_NONE, GNT_REN, GNT_WR, GNT_PF), prefetch state encodings (PF_IDLE, PF_WAIT, PF_READ), address widths.
- One sub-module: vram_wr_fifo (sync FIFO of {addr[13:0], data[7:0]}, with full/empty and count).

Test Plan:
- Reset, then write 0xA5 to 0x0001 with ren_req=0 -> next cycle vram_addr=0x0000, vram_wrbe=2'b10, vram_wrdata=0xA5A5.
- Hold ren_req=1 continuously; push 4 writes -> cpu_wr_ready=0 after the 4th; a 5th held valid is accepted only after ren_req drops; writes reach VRAM in order.
- Write 0x3C to 0x0100, then pulse cpu_pf_start at 0x0100 the same cycle -> the prefetch read follows the write; cpu_rd_valid=1 with cpu_rd_data=0x3C.
- cpu_pf_start at 0x0010, then at 0x0020 during PF_READ -> first data discarded; cpu_rd_valid rises once with the byte from 0x0020.
- ren_req at word 0x1FFF with VRAM holding 0xBEEF -> ren_ack same cycle; ren_rdvalid=1 and ren_rddata=0xBEEF one cycle later.
- With VRAM_ARB_FAIR_EN and CPU_MAX_WAIT=8: ren_req stuck high with one pending write -> the write is granted on cycle 9 and ren_ack=0 for that cycle only.
